serial_to_parallel: RTL and testbench

//   Deserialiser that consumes the registered serial bit stream from the D flip-flop stage.

---
 rtl/serial_to_parallel_if.sv | 37 +++
 rtl/serial_to_parallel.sv | 135 +++++++++++++
 tb/tb_serial_to_parallel.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_if.sv
// Serial-to-parallel bus: serial bit input side plus the word valid/ready output
// side, with status flags. The slave modport is the deserialiser's view; the
// master modport is the view of whatever feeds bits in and consumes words.
interface serial_to_parallel_if #(
   parameter int WIDTH = 8
);
   logic             d;
   logic             d_valid;
   logic [WIDTH-1:0] data;
   logic             data_valid;
   logic             data_ready;
   logic             busy;
   logic             overrun;
   logic             parity_err;

   modport slave (
      input  d,
      input  d_valid,
      input  data_ready,
      output data,
      output data_valid,
      output busy,
      output overrun,
      output parity_err
   );

   modport master (
      output d,
      output d_valid,
      output data_ready,
      input  data,
      input  data_valid,
      input  busy,
      input  overrun,
      input  parity_err
   );
endinterface

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: deserialiser fed by the Dff stage's q output.
// Shifts in one bit per d_valid edge and assembles WIDTH-bit words. Each
// completed word is offered on a valid/ready handshake. A word that completes
// while the previous one is still unconsumed is dropped and sets sticky overrun.
// Optional feature macro: PARITY_CHECK_EN -- each word is followed by one even
// parity bit (expected d = ^word), the word commits on that parity edge, and a
// mismatch sets sticky parity_err. Without the macro, parity_err is tied to 0.
module serial_to_parallel #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic                clk,
   input logic                rst,
   serial_to_parallel_if.slave bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

   state_t           state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shift;
   logic [WIDTH-1:0] shift_next;
   logic [WIDTH-1:0] data_q;
   logic             data_valid_q;
   logic             overrun_q;
   logic             commit;
   logic [WIDTH-1:0] commit_word;
`ifdef PARITY_CHECK_EN
   logic             parity_err_q;
`endif

   // Next shift-register value and whether this edge delivers a finished word.
   always_comb begin
      shift_next  = shift;
      commit      = 1'b0;
      commit_word = shift;
      if (MSB_FIRST) begin
         shift_next = {shift[WIDTH-2:0], bus.d};
      end else begin
         shift_next = {bus.d, shift[WIDTH-1:1]};
      end
`ifdef PARITY_CHECK_EN
      commit      = bus.d_valid && (state == S_PARITY);
      commit_word = shift;
`else
      commit      = bus.d_valid && (state == S_SHIFT) && (bit_cnt == LAST_CNT);
      commit_word = shift_next;
`endif
   end

   // Bit-collection FSM plus the output word register and its handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         bit_cnt      <= '0;
         shift        <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.d_valid) begin
                  shift   <= shift_next;
                  bit_cnt <= CW'(1);
                  state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bus.d_valid) begin
                  shift <= shift_next;
                  if (bit_cnt == LAST_CNT) begin
                     bit_cnt <= '0;
`ifdef PARITY_CHECK_EN
                     state   <= S_PARITY;
`else
                     state   <= S_IDLE;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
               if (bus.d_valid) begin
                  if (bus.d != (^shift)) begin
                     parity_err_q <= 1'b1;
                  end
                  state <= S_IDLE;
               end
            end
`endif
            default: begin
               state   <= S_IDLE;
               bit_cnt <= '0;
            end
         endcase

         // A commit against an unconsumed word that is not being taken this
         // edge loses the new word; otherwise the new word replaces the old.
         if (commit) begin
            if (data_valid_q && !bus.data_ready) begin
               overrun_q <= 1'b1;
            end else begin
               data_q       <= commit_word;
               data_valid_q <= 1'b1;
            end
         end else if (data_valid_q && bus.data_ready) begin
            data_valid_q <= 1'b0;
         end
      end
   end

   assign bus.data       = data_q;
   assign bus.data_valid = data_valid_q;
   assign bus.overrun    = overrun_q;
   assign bus.busy       = (state != S_IDLE);
`ifdef PARITY_CHECK_EN
   assign bus.parity_err = parity_err_q;
`else
   assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed self-checking bench for serial_to_parallel (WIDTH=8, MSB_FIRST=1).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on
// the rising edge. Honours PARITY_CHECK_EN by appending a parity bit to words.
module tb_serial_to_parallel;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests  = 0;
   int   failed = 0;

   serial_to_parallel_if #(.WIDTH(8)) bus ();

   serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Drive one cycle's worth of inputs, then advance past one rising edge.
   task automatic apply_stimulus(input logic b, input logic v, input logic rdy);
      bus.d          = b;
      bus.d_valid    = v;
      bus.data_ready = rdy;
      @(negedge clk);
   endtask

   // Compare one observed value with its expected value.
   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Two reset cycles.
   task automatic do_reset();
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      rst = 1'b0;
   endtask

   // Send an 8-bit word MSB first. rdy_body applies to all edges except the
   // commit edge, which uses rdy_last (parity bit edge when parity is enabled).
   task automatic send_word(input logic [7:0] w, input logic rdy_body, input logic rdy_last);
      for (int i = 7; i >= 1; i--) begin
         apply_stimulus(w[i], 1'b1, rdy_body);
      end
`ifdef PARITY_CHECK_EN
      apply_stimulus(w[0], 1'b1, rdy_body);
      apply_stimulus(^w, 1'b1, rdy_last);
`else
      apply_stimulus(w[0], 1'b1, rdy_last);
`endif
   endtask

   initial begin
      bus.d          = 1'b0;
      bus.d_valid    = 1'b0;
      bus.data_ready = 1'b1;
      @(negedge clk);

      // Test 1: reset state, then 1,0,1,0,0,1,0,1 continuously.
      do_reset();
      check_output("rst_data",       32'(bus.data),  32'h00);
      check_output("rst_valid",      32'(bus.data_valid), 32'd0);
      check_output("rst_busy",       32'(bus.busy),  32'd0);
      check_output("rst_overrun",    32'(bus.overrun), 32'd0);
      check_output("rst_parity_err", 32'(bus.parity_err), 32'd0);
      apply_stimulus(1'b1, 1'b1, 1'b1);
      check_output("t1_busy_bit1",   32'(bus.busy),  32'd1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      check_output("t1_valid_before", 32'(bus.data_valid), 32'd0);
`ifdef PARITY_CHECK_EN
      apply_stimulus(1'b1, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
`else
      apply_stimulus(1'b1, 1'b1, 1'b1);
`endif
      check_output("t1_data",        32'(bus.data),  32'hA5);
      check_output("t1_valid",       32'(bus.data_valid), 32'd1);
      check_output("t1_busy_done",   32'(bus.busy),  32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      check_output("t1_consumed",    32'(bus.data_valid), 32'd0);
      check_output("t1_data_hold",   32'(bus.data),  32'hA5);

      // Test 2: same word with idle gaps after bits 3 and 6.
      apply_stimulus(1'b1, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b1);
      check_output("t2_busy_gap",    32'(bus.busy),  32'd1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      check_output("t2_valid_gap",   32'(bus.data_valid), 32'd0);
      apply_stimulus(1'b0, 1'b1, 1'b1);
`ifdef PARITY_CHECK_EN
      apply_stimulus(1'b1, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
`else
      apply_stimulus(1'b1, 1'b1, 1'b1);
`endif
      check_output("t2_data",        32'(bus.data),  32'hA5);
      check_output("t2_valid",       32'(bus.data_valid), 32'd1);
      apply_stimulus(1'b0, 1'b0, 1'b1);

      // Test 3: overrun with data_ready low.
      send_word(8'h3C, 1'b0, 1'b0);
      check_output("t3_first_data",  32'(bus.data),  32'h3C);
      check_output("t3_first_ovr",   32'(bus.overrun), 32'd0);
      send_word(8'hFF, 1'b0, 1'b0);
      check_output("t3_kept_data",   32'(bus.data),  32'h3C);
      check_output("t3_overrun",     32'(bus.overrun), 32'd1);
      check_output("t3_still_valid", 32'(bus.data_valid), 32'd1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      check_output("t3_consumed",    32'(bus.data_valid), 32'd0);
      check_output("t3_ovr_sticky",  32'(bus.overrun), 32'd1);
      do_reset();
      check_output("t3_ovr_cleared", 32'(bus.overrun), 32'd0);

      // Test 4: commit on the same edge as the pending word is consumed.
      send_word(8'hF0, 1'b0, 1'b0);
      check_output("t4_pending",     32'(bus.data),  32'hF0);
      send_word(8'h0F, 1'b0, 1'b1);
      check_output("t4_data",        32'(bus.data),  32'h0F);
      check_output("t4_valid",       32'(bus.data_valid), 32'd1);
      check_output("t4_overrun",     32'(bus.overrun), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1);

      // Test 5: reset mid-word discards partial bits.
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, 1'b1, 1'b1);
      end
      check_output("t5_busy_mid",    32'(bus.busy),  32'd1);
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      check_output("t5_busy_rst",    32'(bus.busy),  32'd0);
      check_output("t5_data_rst",    32'(bus.data),  32'h00);
      send_word(8'h81, 1'b1, 1'b1);
      check_output("t5_data",        32'(bus.data),  32'h81);
      check_output("t5_valid",       32'(bus.data_valid), 32'd1);
      apply_stimulus(1'b0, 1'b0, 1'b1);

      // Test 6: parity error flag behaviour.
`ifdef PARITY_CHECK_EN
      for (int i = 7; i >= 0; i--) begin
         apply_stimulus(((8'h07 >> i) & 8'h01) != 8'h00, 1'b1, 1'b1);
      end
      apply_stimulus(1'b0, 1'b1, 1'b1);
      check_output("t6_bad_data",    32'(bus.data),  32'h07);
      check_output("t6_parity_err",  32'(bus.parity_err), 32'd1);
      do_reset();
      for (int i = 7; i >= 0; i--) begin
         apply_stimulus(((8'h07 >> i) & 8'h01) != 8'h00, 1'b1, 1'b1);
      end
      apply_stimulus(1'b1, 1'b1, 1'b1);
      check_output("t6_good_data",   32'(bus.data),  32'h07);
      check_output("t6_parity_ok",   32'(bus.parity_err), 32'd0);
`else
      send_word(8'h07, 1'b1, 1'b1);
      check_output("t6_data",        32'(bus.data),  32'h07);
      check_output("t6_parity_tied", 32'(bus.parity_err), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
